// File: rtl/at_tx_arbiter_pkg.sv
// Shared types and defaults for the AT-command UART transmit arbiter.
// Holds the FSM state enum, parameter defaults and the watchdog step helper.
package at_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_SENDING = 2'd2
  } state_e;

  localparam int NREQ_DEF = 3;
  localparam int BYTE_W   = 8;
  localparam int WD_W     = 27;

  localparam logic [WD_W-1:0] IDLE_MAX_DEF = 27'd90_000;
  localparam logic [WD_W-1:0] TX_MAX_DEF   = 27'd90_000;

  // The watchdog holds at all-ones instead of wrapping back to zero.
  function automatic logic [WD_W-1:0] wd_step(input logic [WD_W-1:0] v);
    wd_step = (v == {WD_W{1'b1}}) ? v : (v + 27'd1);
  endfunction

endpackage

// File: rtl/at_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request searching upward
// from ptr+1, wrapping modulo NREQ.
import at_pkg::*;

module rr_pick #(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [PW-1:0]   o_sel,
  output logic            o_any
);

  int w_dist;
  int w_best;

  // Smallest rotational distance past ptr wins.
  always_comb begin
    o_sel  = '0;
    w_best = NREQ;
    w_dist = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_dist = (i + (2 * NREQ) - 1 - int'(i_ptr)) % NREQ;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        o_sel  = PW'(i);
      end else begin
        w_best = w_best;
      end
    end
    o_any = |i_req;
  end

endmodule

// File: rtl/at_tx_arbiter.sv
// Round-robin session arbiter sharing one UART transmitter between several
// AT-command sequencers, with idle and in-flight watchdogs.
import at_pkg::*;

module at_tx_arbiter #(
  parameter int              NREQ     = NREQ_DEF,
  parameter logic [WD_W-1:0] IDLE_MAX = IDLE_MAX_DEF,
  parameter logic [WD_W-1:0] TX_MAX   = TX_MAX_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ-1:0]      i_byte_valid,
  input  logic [8*NREQ-1:0]    i_byte_data,
  output logic [NREQ-1:0]      o_gnt,
  output logic [NREQ-1:0]      o_byte_ack,
  output logic [NREQ-1:0]      o_byte_done,
  output logic [NREQ-1:0]      o_timeout_err,
  output logic                 o_tx_enable,
  output logic [BYTE_W-1:0]    o_tx_data,
  input  logic                 i_tx_done
);

  localparam int PW = $clog2(NREQ);

  state_e            r_state, w_state;
  logic [PW-1:0]     r_ptr, w_ptr;
  logic [WD_W-1:0]   r_wd, w_wd;
  logic [NREQ-1:0]   r_gnt, w_gnt;
  logic [NREQ-1:0]   r_byte_ack, w_byte_ack;
  logic [NREQ-1:0]   r_byte_done, w_byte_done;
  logic [NREQ-1:0]   r_timeout_err, w_timeout_err;
  logic              r_tx_enable, w_tx_enable;
  logic [BYTE_W-1:0] r_tx_data, w_tx_data;
  logic [PW-1:0]     w_sel;
  logic              w_any;

  function automatic logic [NREQ-1:0] f_onehot(input logic [PW-1:0] idx);
    f_onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_rr_pick (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_sel (w_sel),
    .o_any (w_any)
  );

  // Next-state and next-output logic; r_ptr doubles as the current owner index.
  always_comb begin
    w_state       = r_state;
    w_ptr         = r_ptr;
    w_wd          = r_wd;
    w_gnt         = r_gnt;
    w_byte_ack    = '0;
    w_byte_done   = '0;
    w_timeout_err = '0;
    w_tx_enable   = r_tx_enable;
    w_tx_data     = r_tx_data;
    case (r_state)
      ST_IDLE: begin
        w_gnt = '0;
        if (w_any) begin
          w_gnt   = f_onehot(w_sel);
          w_ptr   = w_sel;
          w_wd    = '0;
          w_state = ST_GRANTED;
        end else begin
          w_state = ST_IDLE;
        end
      end
      ST_GRANTED: begin
        if (!i_req[r_ptr]) begin
          w_gnt   = '0;
          w_state = ST_IDLE;
        end else if (i_byte_valid[r_ptr]) begin
          w_tx_data   = i_byte_data[{r_ptr, 3'b000} +: BYTE_W];
          w_tx_enable = 1'b1;
          w_byte_ack  = f_onehot(r_ptr);
          w_wd        = '0;
          w_state     = ST_SENDING;
        end else if (r_wd == (IDLE_MAX - 27'd1)) begin
          w_timeout_err = f_onehot(r_ptr);
          w_gnt         = '0;
          w_state       = ST_IDLE;
        end else begin
          w_wd = wd_step(r_wd);
        end
      end
      ST_SENDING: begin
        // A request drop is only acted on once the byte has finished.
        if (i_tx_done) begin
          w_tx_enable = 1'b0;
          w_byte_done = f_onehot(r_ptr);
          w_wd        = '0;
          w_state     = ST_GRANTED;
        end else if (r_wd == (TX_MAX - 27'd1)) begin
          w_tx_enable   = 1'b0;
          w_timeout_err = f_onehot(r_ptr);
          w_state       = ST_GRANTED;
        end else begin
          w_wd = wd_step(r_wd);
        end
      end
      default: begin
        w_state     = ST_IDLE;
        w_gnt       = '0;
        w_tx_enable = 1'b0;
      end
    endcase
  end

  // State, pointer, watchdog and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_ptr         <= PW'(NREQ - 1);
      r_wd          <= '0;
      r_gnt         <= '0;
      r_byte_ack    <= '0;
      r_byte_done   <= '0;
      r_timeout_err <= '0;
      r_tx_enable   <= 1'b0;
      r_tx_data     <= 8'h00;
    end else begin
      r_state       <= w_state;
      r_ptr         <= w_ptr;
      r_wd          <= w_wd;
      r_gnt         <= w_gnt;
      r_byte_ack    <= w_byte_ack;
      r_byte_done   <= w_byte_done;
      r_timeout_err <= w_timeout_err;
      r_tx_enable   <= w_tx_enable;
      r_tx_data     <= w_tx_data;
    end
  end

  assign o_gnt         = r_gnt;
  assign o_byte_ack    = r_byte_ack;
  assign o_byte_done   = r_byte_done;
  assign o_timeout_err = r_timeout_err;
  assign o_tx_enable   = r_tx_enable;
  assign o_tx_data     = r_tx_data;

endmodule

// File: tb/tb_at_tx_arbiter.sv
// Self-checking bench for at_tx_arbiter: directed scenarios with literal
// expectations plus random traffic compared each cycle to a session-level model.
module tb_at_tx_arbiter;

  localparam int N    = 3;
  localparam int IMAX = 100;
  localparam int TMAX = 50;

  logic           clk     = 1'b0;
  logic           rst     = 1'b0;
  logic [N-1:0]   req     = '0;
  logic [N-1:0]   valid   = '0;
  logic [8*N-1:0] data    = '0;
  logic           tx_done = 1'b0;
  logic [N-1:0]   gnt, ack, done, err;
  logic           tx_en;
  logic [7:0]     txd;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int ack_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  at_tx_arbiter #(.NREQ(N), .IDLE_MAX(27'd100), .TX_MAX(27'd50)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req         (req),
    .i_byte_valid  (valid),
    .i_byte_data   (data),
    .o_gnt         (gnt),
    .o_byte_ack    (ack),
    .o_byte_done   (done),
    .o_timeout_err (err),
    .o_tx_enable   (tx_en),
    .o_tx_data     (txd),
    .i_tx_done     (tx_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic bit bit_at(input logic [7:0] v, input int i);
    logic [2:0] ix;
    ix = i[2:0];
    return v[ix];
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (bit_at(8'(v), i) && r < 0) r = i;
    return r;
  endfunction

  // Session-level reference: owner (-1 = nobody), byte in flight, cycle counter.
  int           m_owner = -1;
  int           m_last  = N - 1;
  int           m_cnt   = 0;
  bit           m_busy  = 1'b0;
  logic [N-1:0] e_gnt = '0, e_ack = '0, e_done = '0, e_err = '0;
  logic         e_txen = 1'b0;
  logic [7:0]   e_txd  = 8'h00;
  logic [8*N-1:0] m_sh;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_last = N - 1; m_cnt = 0; m_busy = 1'b0;
      e_gnt = '0; e_ack = '0; e_done = '0; e_err = '0; e_txen = 1'b0; e_txd = 8'h00;
    end else begin
      e_ack = '0; e_done = '0; e_err = '0;
      if (m_owner < 0) begin
        for (int k = 1; k <= N; k++)
          if (m_owner < 0 && bit_at(8'(req), (m_last + k) % N)) m_owner = (m_last + k) % N;
        if (m_owner >= 0) begin
          m_last = m_owner;
          m_cnt  = 0;
        end
      end else if (!m_busy) begin
        if (!bit_at(8'(req), m_owner)) begin
          m_owner = -1;
        end else if (bit_at(8'(valid), m_owner)) begin
          m_sh   = data >> (8 * m_owner);
          e_txd  = m_sh[7:0];
          m_busy = 1'b1;
          e_ack  = N'(1) << m_owner;
          m_cnt  = 0;
        end else if (m_cnt == IMAX - 1) begin
          e_err   = N'(1) << m_owner;
          m_owner = -1;
        end else begin
          m_cnt++;
        end
      end else begin
        if (tx_done) begin
          m_busy = 1'b0;
          e_done = N'(1) << m_owner;
          m_cnt  = 0;
        end else if (m_cnt == TMAX - 1) begin
          m_busy = 1'b0;
          e_err  = N'(1) << m_owner;
        end else begin
          m_cnt++;
        end
      end
      e_gnt  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      e_txen = m_busy;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_cmp", 32'({gnt, ack, done, err, tx_en, txd}),
            32'({e_gnt, e_ack, e_done, e_err, e_txen, e_txd}));
    end
    ack_cnt  += 32'(ack[0]);
    done_cnt += 32'(done[0]);
  end

  task automatic wait_gnt(output int g);
    for (int k = 0; k < 20 && gnt == '0; k++) tick();
    check("wait_gnt", 32'(gnt != '0), 32'd1);
    g = idx_of(gnt);
  endtask

  logic [7:0] seq [4] = '{8'h41, 8'h54, 8'h0d, 8'h0a};
  int         order_exp [4] = '{0, 1, 2, 0};

  initial begin
    int g, early;
    logic [N-1:0] gs;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 chk_en = 1'b1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_txen", 32'(tx_en), 32'd0);
    check("rst_txd", 32'(txd), 32'd0);
    check("rst_pulses", 32'({ack, done, err}), 32'd0);
    rst = 1'b0;
    tick();

    // Single owner, four bytes, UART answers 20 cycles after each tx_enable.
    req = 3'b001;
    tick();
    check("t1_gnt", 32'(gnt), 32'd1);
    ack_cnt = 0; done_cnt = 0;
    for (int b = 0; b < 4; b++) begin
      data[7:0] = seq[b]; valid[0] = 1'b1;
      tick();
      valid[0] = 1'b0;
      check("t1_ack", 32'(ack), 32'd1);
      check("t1_txd", 32'(txd), 32'(seq[b]));
      check("t1_txen", 32'(tx_en), 32'd1);
      repeat (19) tick();
      check("t1_still_busy", 32'(tx_en), 32'd1);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      check("t1_done", 32'(done), 32'd1);
      check("t1_txen_low", 32'(tx_en), 32'd0);
      check("t1_gnt_hold", 32'(gnt), 32'd1);
    end
    tick();
    check("t1_ack_cnt", 32'(ack_cnt), 32'd4);
    check("t1_done_cnt", 32'(done_cnt), 32'd4);
    req = 3'b000;
    tick();
    check("t1_release", 32'(gnt), 32'd0);

    // Contention from reset: grant order 0,1,2,0.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 3'b111;
    for (int s = 0; s < 4; s++) begin
      wait_gnt(g);
      check("t2_order", 32'(g), 32'(order_exp[s]));
      gs = gnt;
      valid = gs; data = 24'($urandom);
      tick();
      valid = '0;
      check("t2_ack", 32'(ack), 32'(gs));
      repeat (3) tick();
      tx_done = 1'b1; tick(); tx_done = 1'b0;
      check("t2_done", 32'(done), 32'(gs));
      req = req & ~gs;
      tick();
      check("t2_release", 32'(gnt), 32'd0);
      req = 3'b111;
    end

    // Release while a byte is in flight.
    req = 3'b010;
    wait_gnt(g);
    check("t3_gnt", 32'(gnt), 32'd2);
    valid[1] = 1'b1; data[15:8] = 8'h5a;
    tick();
    valid[1] = 1'b0; req[1] = 1'b0;
    check("t3_ack", 32'(ack), 32'd2);
    repeat (3) tick();
    check("t3_gnt_hold", 32'(gnt), 32'd2);
    check("t3_txen", 32'(tx_en), 32'd1);
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    check("t3_done", 32'(done), 32'd2);
    check("t3_gnt_after_done", 32'(gnt), 32'd2);
    tick();
    check("t3_gnt_drop", 32'(gnt), 32'd0);

    // Idle watchdog: requester 2 never offers a byte.
    req = 3'b101;
    tick();
    check("t4_gnt", 32'(gnt), 32'd4);
    early = 0;
    repeat (99) begin
      tick();
      if (err != '0) early++;
    end
    check("t4_no_early_err", 32'(early), 32'd0);
    tick();
    check("t4_err", 32'(err), 32'd4);
    check("t4_gnt_revoked", 32'(gnt), 32'd0);
    tick();
    check("t4_next_gnt", 32'(gnt), 32'd1);

    // TX watchdog: UART never answers.
    data[7:0] = 8'h55; valid[0] = 1'b1;
    tick();
    valid[0] = 1'b0;
    check("t5_ack", 32'(ack), 32'd1);
    repeat (49) tick();
    check("t5_txen_49", 32'(tx_en), 32'd1);
    check("t5_err_49", 32'(err), 32'd0);
    tick();
    check("t5_txen_50", 32'(tx_en), 32'd0);
    check("t5_err_50", 32'(err), 32'd1);
    check("t5_gnt", 32'(gnt), 32'd1);
    data[7:0] = 8'h66; valid[0] = 1'b1;
    tick();
    valid[0] = 1'b0;
    check("t5_next_ack", 32'(ack), 32'd1);
    check("t5_next_txd", 32'(txd), 32'h66);

    // Reset while sending.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_txen", 32'(tx_en), 32'd0);
    check("t6_gnt", 32'(gnt), 32'd0);
    check("t6_txd", 32'(txd), 32'd0);
    req = 3'b111;
    tick();
    rst = 1'b0;
    tick();
    check("t6_first_gnt", 32'(gnt), 32'd1);

    // Random traffic against the model.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(99) < 3) req[i] = ~req[i];
        valid[i] = ($urandom_range(99) < 30);
      end
      data    = 24'($urandom);
      tx_done = ($urandom_range(99) < 3);
      tick();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
